// File: rtl/count_evt_pkg.sv
// -----------------------------------------------------------------------------
// count_evt_pkg
//   Shared definitions for the count_match_event block: FSM state encoding,
//   event type bit assignments and a helper that builds the event type field.
// -----------------------------------------------------------------------------
package count_evt_pkg;

    // FSM state encoding kept as plain logic constants for legacy compatibility.
    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'd0;
    localparam state_t StArmed   = 2'd1;
    localparam state_t StPending = 2'd2;
    localparam state_t StHoldoff = 2'd3;

    // Event type bits; both can be set when a compare match coincides with a wrap.
    localparam logic [1:0] EVT_MATCH = 2'b01;
    localparam logic [1:0] EVT_WRAP  = 2'b10;

    function automatic logic [1:0] evt_type(input logic match, input logic wrap);
        logic [1:0] t;
        t = 2'b00;
        if (match) t = t | EVT_MATCH;
        if (wrap)  t = t | EVT_WRAP;
        return t;
    endfunction

endpackage

// File: rtl/count_edge_detect.sv
// -----------------------------------------------------------------------------
// count_edge_detect
//   Tracks the previous counter value and flags the conditions that can raise
//   an event. The previous-value register runs every cycle regardless of the
//   consumer FSM, so a counter that stops moving never re-fires.
//
// Ports
//   Clock        in   1      clock, all state on posedge
//   Reset        in   1      synchronous, active-high
//   Count_Value  in   WIDTH  counter value being watched
//   Cmp_Reg      in   WIDTH  registered compare value
//   Change       out  1      Count_Value differs from last cycle
//   Match        out  1      counter moved onto the compare value
//   Wrap         out  1      counter went from all ones to zero
// -----------------------------------------------------------------------------
module count_edge_detect
    import count_evt_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Count_Value,
    input  logic [WIDTH-1:0] Cmp_Reg,
    output logic             Change,
    output logic             Match,
    output logic             Wrap
);

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= Count_Value;
        end
    end

    always_comb begin
        Change = (Count_Value != prev_q);
        // Gating with Change keeps a counter parked on the compare value silent.
        Match  = Change && (Count_Value == Cmp_Reg);
        Wrap   = (prev_q == {WIDTH{1'b1}}) && (Count_Value == '0);
    end

endmodule

// File: rtl/count_match_event.sv
// -----------------------------------------------------------------------------
// count_match_event
//   Watches a 16-bit loadable counter and raises a held event when the count
//   reaches a programmed compare value or wraps from all ones to zero. Each
//   event captures the count and type and is handed to control logic with a
//   valid/ack handshake. After ack an optional holdoff runs, then the block
//   re-arms itself or drops back to idle. A sticky Missed flag records
//   qualifying events that arrived while an event was pending or in holdoff.
//
// Parameters
//   WIDTH       counter/compare width
//   HOLDOFF     cycles spent in holdoff after ack (0 skips the holdoff state)
//   AUTO_REARM  1: holdoff returns to armed; 0: holdoff returns to idle
//
// Ports
//   Clock        in   1      single clock, all state on posedge
//   Reset        in   1      synchronous, active-high, overrides all inputs
//   Count_Value  in   WIDTH  counter output being watched
//   Cmp_Value    in   WIDTH  compare value, loaded on Cmp_Write
//   Cmp_Write    in   1      load Cmp_Value into the compare register
//   Arm          in   1      idle -> armed; clears Missed in any state
//   Disarm       in   1      any state -> idle, drops Event_Valid
//   Event_Ack    in   1      consumer accepts the pending event
//   Event_Valid  out  1      event pending, held until ack or disarm
//   Event_Type   out  2      [0] compare match, [1] wrap
//   Event_Count  out  WIDTH  Count_Value captured at the event
//   Missed       out  1      sticky: event seen while pending or in holdoff
//   Armed        out  1      FSM is in the armed state
// -----------------------------------------------------------------------------
module count_match_event
    import count_evt_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned HOLDOFF    = 2,
    parameter int unsigned AUTO_REARM = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Count_Value,
    input  logic [WIDTH-1:0] Cmp_Value,
    input  logic             Cmp_Write,
    input  logic             Arm,
    input  logic             Disarm,
    input  logic             Event_Ack,
    output logic             Event_Valid,
    output logic [1:0]       Event_Type,
    output logic [WIDTH-1:0] Event_Count,
    output logic             Missed,
    output logic             Armed
);

    // Holdoff counter needs at least one bit even when the holdoff is skipped.
    localparam int unsigned HoldW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    // Value the counter holds on the last holdoff cycle; unused when HOLDOFF is 0.
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF - 1);
    localparam state_t PostHoldoff = (AUTO_REARM != 0) ? StArmed : StIdle;

    logic [WIDTH-1:0] cmp_reg_q;
    state_t           state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             valid_q, valid_d;
    logic [1:0]       type_q, type_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             missed_q, missed_d;

    logic change;
    logic match;
    logic wrap;
    logic qual;

    count_edge_detect #(
        .WIDTH (WIDTH)
    ) u_edge_detect (
        .Clock       (Clock),
        .Reset       (Reset),
        .Count_Value (Count_Value),
        .Cmp_Reg     (cmp_reg_q),
        .Change      (change),
        .Match       (match),
        .Wrap        (wrap)
    );

    assign qual = match | wrap;

    // Compare register: a write lands on this edge, so the same-cycle compare
    // still sees the old value.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cmp_reg_q <= '0;
        end else if (Cmp_Write) begin
            cmp_reg_q <= Cmp_Value;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        valid_d    = valid_q;
        type_d     = type_q;
        count_d    = count_q;
        missed_d   = missed_q;

        // Arm clears first so a simultaneous lost event still sets the flag.
        if (Arm) begin
            missed_d = 1'b0;
        end
        if (qual && ((state_q == StPending) || (state_q == StHoldoff))) begin
            missed_d = 1'b1;
        end

        if (Disarm) begin
            // Captured type/count deliberately survive a disarm.
            state_d    = StIdle;
            valid_d    = 1'b0;
            hold_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Arm) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (qual) begin
                        state_d = StPending;
                        valid_d = 1'b1;
                        type_d  = evt_type(match, wrap);
                        count_d = Count_Value;
                    end
                end
                StPending: begin
                    if (Event_Ack) begin
                        valid_d    = 1'b0;
                        hold_cnt_d = '0;
                        state_d    = (HOLDOFF == 0) ? PostHoldoff : StHoldoff;
                    end
                end
                StHoldoff: begin
                    if (hold_cnt_q == HoldLast) begin
                        hold_cnt_d = '0;
                        state_d    = PostHoldoff;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            valid_q    <= 1'b0;
            type_q     <= 2'b00;
            count_q    <= '0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            valid_q    <= valid_d;
            type_q     <= type_d;
            count_q    <= count_d;
            missed_q   <= missed_d;
        end
    end

    always_comb begin
        Event_Valid = valid_q;
        Event_Type  = type_q;
        Event_Count = count_q;
        Missed      = missed_q;
        Armed       = (state_q == StArmed);
    end

    // change is only consumed inside match; keep it visible for debug taps.
    logic unused_change;
    assign unused_change = change;

endmodule

// File: tb/tb_count_match_event.sv
module tb_count_match_event;

    logic        Clock = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cv = '0;
    logic [15:0] cmp_v = '0;
    logic        cmp_w = 1'b0;

    // Instance A: default parameters (HOLDOFF=2, AUTO_REARM=1)
    logic        arm = 1'b0, disarm = 1'b0, ack = 1'b0;
    logic        ev_valid, missed, armed;
    logic [1:0]  ev_type;
    logic [15:0] ev_count;

    // Instance B: HOLDOFF=0, AUTO_REARM=0
    logic        arm_b = 1'b0, disarm_b = 1'b0, ack_b = 1'b0;
    logic        ev_valid_b, missed_b, armed_b;
    logic [1:0]  ev_type_b;
    logic [15:0] ev_count_b;

    always #5 Clock = ~Clock;

    count_match_event #(
        .WIDTH      (16),
        .HOLDOFF    (2),
        .AUTO_REARM (1)
    ) dut_a (
        .Clock       (Clock),
        .Reset       (rst),
        .Count_Value (cv),
        .Cmp_Value   (cmp_v),
        .Cmp_Write   (cmp_w),
        .Arm         (arm),
        .Disarm      (disarm),
        .Event_Ack   (ack),
        .Event_Valid (ev_valid),
        .Event_Type  (ev_type),
        .Event_Count (ev_count),
        .Missed      (missed),
        .Armed       (armed)
    );

    count_match_event #(
        .WIDTH      (16),
        .HOLDOFF    (0),
        .AUTO_REARM (0)
    ) dut_b (
        .Clock       (Clock),
        .Reset       (rst),
        .Count_Value (cv),
        .Cmp_Value   (cmp_v),
        .Cmp_Write   (cmp_w),
        .Arm         (arm_b),
        .Disarm      (disarm_b),
        .Event_Ack   (ack_b),
        .Event_Valid (ev_valid_b),
        .Event_Type  (ev_type_b),
        .Event_Count (ev_count_b),
        .Missed      (missed_b),
        .Armed       (armed_b)
    );

    typedef struct packed {
        logic [1:0]  t;
        logic [15:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare a fresh event against the oldest scoreboard entry.
    task automatic pop_evt(input string tag, input logic v, input logic [1:0] t,
                           input logic [15:0] c);
        exp_t e;
        chk({tag, "_valid"}, {31'd0, v}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_type"}, {30'd0, t}, {30'd0, e.t});
            chk({tag, "_count"}, {16'd0, c}, {16'd0, e.c});
        end
    endtask

    task automatic write_cmp(input logic [15:0] v);
        cmp_v = v;
        cmp_w = 1'b1;
        step();
        cmp_w = 1'b0;
    endtask

    // Ack on A, then walk through the 2-cycle holdoff back to armed.
    task automatic ack_and_rearm(input string tag);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, ev_valid}, 32'd0);
        chk({tag, "_hold1"}, {31'd0, armed}, 32'd0);
        step();
        chk({tag, "_hold2"}, {31'd0, armed}, 32'd0);
        step();
        chk({tag, "_rearm"}, {31'd0, armed}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        chk("rst_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_type", {30'd0, ev_type}, 32'd0);
        chk("rst_count", {16'd0, ev_count}, 32'd0);
        chk("rst_missed", {31'd0, missed}, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        rst = 1'b0;

        // Compare match at 5
        write_cmp(16'h0005);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("arm", {31'd0, armed}, 32'd1);
        for (int v = 1; v <= 8; v++) begin
            cv = 16'(v);
            if (v == 5) exp_q.push_back('{t: 2'b01, c: 16'h0005});
            step();
            if (v == 4) chk("pre_match", {31'd0, ev_valid}, 32'd0);
            if (v == 5) pop_evt("match", ev_valid, ev_type, ev_count);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_valid", {31'd0, ev_valid}, 32'd1);
            chk("hold_type", {30'd0, ev_type}, 32'd1);
            chk("hold_count", {16'd0, ev_count}, 32'h5);
        end
        ack_and_rearm("ack1");

        // Wrap event
        cv = 16'hFFFE;
        step();
        cv = 16'hFFFF;
        step();
        cv = 16'h0000;
        exp_q.push_back('{t: 2'b10, c: 16'h0000});
        step();
        pop_evt("wrap", ev_valid, ev_type, ev_count);
        ack_and_rearm("ack2");

        // Wrap coinciding with compare at 0
        cv = 16'hFFFE;
        write_cmp(16'h0000);
        cv = 16'hFFFF;
        step();
        cv = 16'h0000;
        exp_q.push_back('{t: 2'b11, c: 16'h0000});
        step();
        pop_evt("wrap_match", ev_valid, ev_type, ev_count);
        ack_and_rearm("ack3");

        // Stalled counter sitting on the compare value never fires
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        chk("disarm_idle", {31'd0, armed}, 32'd0);
        cv = 16'h0005;
        step();
        write_cmp(16'h0005);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("stall_armed", {31'd0, armed}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_quiet", {31'd0, ev_valid}, 32'd0);
        end

        // Missed while pending, then Arm clears it
        cv = 16'h0004;
        step();
        cv = 16'h0005;
        exp_q.push_back('{t: 2'b01, c: 16'h0005});
        step();
        pop_evt("match2", ev_valid, ev_type, ev_count);
        cv = 16'h0004;
        step();
        chk("no_miss_yet", {31'd0, missed}, 32'd0);
        cv = 16'h0005;
        step();
        chk("missed_set", {31'd0, missed}, 32'd1);
        chk("missed_valid", {31'd0, ev_valid}, 32'd1);
        chk("missed_count", {16'd0, ev_count}, 32'h5);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("missed_clr", {31'd0, missed}, 32'd0);
        chk("missed_clr_valid", {31'd0, ev_valid}, 32'd1);
        ack_and_rearm("ack4");

        // Reset in the middle of a pending event
        cv = 16'h0004;
        step();
        cv = 16'h0005;
        exp_q.push_back('{t: 2'b01, c: 16'h0005});
        step();
        pop_evt("match3", ev_valid, ev_type, ev_count);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid", {31'd0, ev_valid}, 32'd0);
        chk("mrst_type", {30'd0, ev_type}, 32'd0);
        chk("mrst_count", {16'd0, ev_count}, 32'd0);
        chk("mrst_missed", {31'd0, missed}, 32'd0);
        chk("mrst_armed", {31'd0, armed}, 32'd0);
        // Compare is back at 0; moving onto 0 must not fire from idle.
        cv = 16'h0001;
        step();
        cv = 16'h0000;
        step();
        chk("mrst_idle", {31'd0, ev_valid}, 32'd0);

        // Instance B: no holdoff, no auto-rearm
        write_cmp(16'h0005);
        arm_b = 1'b1;
        step();
        arm_b = 1'b0;
        chk("b_arm", {31'd0, armed_b}, 32'd1);
        cv = 16'h0004;
        step();
        cv = 16'h0005;
        exp_q.push_back('{t: 2'b01, c: 16'h0005});
        step();
        pop_evt("b_match", ev_valid_b, ev_type_b, ev_count_b);
        ack_b = 1'b1;
        step();
        ack_b = 1'b0;
        chk("b_ack_valid", {31'd0, ev_valid_b}, 32'd0);
        chk("b_ack_idle", {31'd0, armed_b}, 32'd0);
        cv = 16'h0004;
        step();
        cv = 16'h0005;
        step();
        chk("b_idle_quiet", {31'd0, ev_valid_b}, 32'd0);
        arm_b = 1'b1;
        step();
        arm_b = 1'b0;
        cv = 16'h0004;
        step();
        cv = 16'h0005;
        exp_q.push_back('{t: 2'b01, c: 16'h0005});
        step();
        pop_evt("b_match2", ev_valid_b, ev_type_b, ev_count_b);
        disarm_b = 1'b1;
        step();
        disarm_b = 1'b0;
        chk("b_dis_valid", {31'd0, ev_valid_b}, 32'd0);
        chk("b_dis_armed", {31'd0, armed_b}, 32'd0);
        chk("b_dis_type", {30'd0, ev_type_b}, 32'd1);
        chk("b_dis_count", {16'd0, ev_count_b}, 32'h5);
        cv = 16'h0004;
        step();
        cv = 16'h0005;
        step();
        chk("b_dis_quiet", {31'd0, ev_valid_b}, 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
